if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_pkg.sv | 28 ++
 rtl/if_fetch_buf.sv | 62 ++++++
 rtl/if_fetch.sv | 103 ++++++++++
 tb/tb_if_fetch.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: RV32 opcodes, reset
// defaults and the fetch FSM state encoding.
package if_fetch_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_WORD   = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetchState_e;

   function automatic logic [31:0] alignPc(input logic [31:0] pc);
      return pc & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// Two-entry FIFO of {pc, word} pairs sitting between instruction memory
// and the decoder; flush empties it in a single cycle.
module if_buf (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push_i,
   input  logic [31:0] pushPc_i,
   input  logic [31:0] pushWord_i,
   input  logic        pop_i,
   input  logic        flush_i,
   output logic [31:0] headPc_o,
   output logic [31:0] headWord_o,
   output logic        full_o,
   output logic        empty_o,
   output logic [1:0]  count_o
);

   logic [31:0] pc_q   [2];
   logic [31:0] word_q [2];
   logic        rdPtr_q, rdPtr_d;
   logic [1:0]  count_q, count_d;
   logic        doPush, doPop, wrPtr;

   // With only two slots the write slot is the head slot when the count is
   // even and the other slot when it is odd.
   always_comb begin
      doPop   = pop_i && (count_q != 2'd0);
      doPush  = push_i && ((count_q != 2'd2) || doPop);
      wrPtr   = rdPtr_q ^ count_q[0];
      rdPtr_d = rdPtr_q ^ doPop;
      count_d = count_q + {1'b0, doPush} - {1'b0, doPop};
      if (flush_i) begin
         rdPtr_d = 1'b0;
         count_d = 2'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdPtr_q <= 1'b0;
         count_q <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            pc_q[i]   <= 32'h0;
            word_q[i] <= 32'h0;
         end
      end else begin
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
         if (doPush && !flush_i) begin
            pc_q[wrPtr]   <= pushPc_i;
            word_q[wrPtr] <= pushWord_i;
         end
      end
   end

   assign headPc_o   = pc_q[rdPtr_q];
   assign headWord_o = word_q[rdPtr_q];
   assign full_o     = (count_q == 2'd2);
   assign empty_o    = (count_q == 2'd0);
   assign count_o    = count_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues one outstanding memory request at a time,
// buffers returned words for the decoder and handles execute redirects.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        id_ready
);

   fetchState_e state_q, state_d;
   logic [31:0] fpc_q, fpc_d;
   logic [31:0] reqPc_q, reqPc_d;
   logic        outstanding, granted;
   logic [1:0]  occupancy;
   logic        bufPush, bufPop, bufFull, bufEmpty;
   logic [1:0]  bufCount;
   logic [31:0] headPc, headWord;

   assign outstanding = (state_q != IDLE);
   assign occupancy   = bufCount + {1'b0, outstanding};
   assign imem_req    = rst_n && !outstanding && (occupancy < 2'd2);
   assign imem_addr   = fpc_q;
   assign granted     = imem_req && imem_gnt;

   // A redirect always wins over the sequential fpc+4 step; a request granted
   // in the redirect cycle is already stale, so its response must be dropped.
   always_comb begin
      state_d = state_q;
      fpc_d   = fpc_q;
      reqPc_d = reqPc_q;
      case (state_q)
         IDLE: begin
            if (granted) begin
               state_d = redirect_valid ? DROP : WAIT;
               reqPc_d = fpc_q;
               fpc_d   = fpc_q + 32'd4;
            end
         end
         WAIT: begin
            if (imem_rvalid)
               state_d = IDLE;
            else if (redirect_valid)
               state_d = DROP;
         end
         DROP: begin
            if (imem_rvalid)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (redirect_valid)
         fpc_d = alignPc(redirect_pc);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         fpc_q   <= alignPc(RESET_PC);
         reqPc_q <= 32'h0;
      end else begin
         state_q <= state_d;
         fpc_q   <= fpc_d;
         reqPc_q <= reqPc_d;
      end
   end

   assign bufPop  = instr_valid && id_ready;
   assign bufPush = (state_q == WAIT) && imem_rvalid && !redirect_valid && (!bufFull || bufPop);

   if_buf u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (bufPush),
      .pushPc_i   (reqPc_q),
      .pushWord_i (imem_rdata),
      .pop_i      (bufPop),
      .flush_i    (redirect_valid),
      .headPc_o   (headPc),
      .headWord_o (headWord),
      .full_o     (bufFull),
      .empty_o    (bufEmpty),
      .count_o    (bufCount)
   );

   assign instr_valid = !bufEmpty;
   assign instr       = bufEmpty ? NOP_INSTR : headWord;
   assign instr_pc    = bufEmpty ? 32'h0 : headPc;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_if_fetch;

   localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] TB_NOP      = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        id_ready;

   int checks   = 0;
   int failures = 0;

   // Reference model: fetch address, queue of delivered {pc, word}, and
   // whether one request is in flight and whether its data is stale.
   logic [31:0] mFpc;
   logic [31:0] mQPc[$];
   logic [31:0] mQWord[$];
   bit          mOut;
   bit          mDiscard;
   logic [31:0] mReqAddr;

   // Memory responder: one pending response with a random delay.
   bit          memPending;
   int          memDelay;
   int          latMax;
   bit          fixData;
   logic [31:0] fixedData;

   if_fetch #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0013)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .id_ready       (id_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      mFpc = TB_RESET_PC;
      mQPc.delete();
      mQWord.delete();
      mOut = 1'b0;
      mDiscard = 1'b0;
      mReqAddr = 32'h0;
      memPending = 1'b0;
      memDelay = 0;
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_req"}, 32'(imem_req), 32'h0);
      checkOutput({tag, "_addr"}, imem_addr, TB_RESET_PC);
      checkOutput({tag, "_valid"}, 32'(instr_valid), 32'h0);
      checkOutput({tag, "_instr"}, instr, TB_NOP);
      checkOutput({tag, "_pc"}, instr_pc, 32'h0);
   endtask

   // Called at a falling edge: drives one cycle of inputs, checks outputs,
   // advances the model across the rising edge, returns at the next falling edge.
   task automatic applyStimulus(input bit gnt, input bit ready, input bit redir,
                                input logic [31:0] redirPc, input bit forceRv);
      bit          rv;
      bit          expReq;
      bit          pop;
      bit          granted;
      logic [31:0] data;
      rv   = (memPending && memDelay == 0) || forceRv;
      data = fixData ? fixedData : $urandom;
      imem_gnt       = gnt;
      imem_rvalid    = rv;
      imem_rdata     = data;
      id_ready       = ready;
      redirect_valid = redir;
      redirect_pc    = redirPc;
      #1;
      expReq = !mOut && (mQPc.size() < 2);
      checkOutput("imem_req", 32'(imem_req), 32'(expReq));
      checkOutput("imem_addr", imem_addr, mFpc);
      checkOutput("instr_valid", 32'(instr_valid), 32'(mQPc.size() > 0));
      if (mQPc.size() > 0) begin
         checkOutput("instr", instr, mQWord[0]);
         checkOutput("instr_pc", instr_pc, mQPc[0]);
      end else begin
         checkOutput("instr_nop", instr, TB_NOP);
         checkOutput("instr_pc_empty", instr_pc, 32'h0);
      end
      @(posedge clk);
      pop     = (mQPc.size() > 0) && ready;
      granted = expReq && gnt;
      if (pop) begin
         void'(mQPc.pop_front());
         void'(mQWord.pop_front());
      end
      if (mOut && rv) begin
         if (!mDiscard && !redir) begin
            mQPc.push_back(mReqAddr);
            mQWord.push_back(data);
         end
         mOut = 1'b0;
         mDiscard = 1'b0;
      end else if (!mOut && granted) begin
         mOut = 1'b1;
         mReqAddr = mFpc;
         mFpc = mFpc + 32'd4;
         mDiscard = redir;
      end else if (mOut && redir) begin
         mDiscard = 1'b1;
      end
      if (redir) begin
         mQPc.delete();
         mQWord.delete();
         mFpc = redirPc & 32'hFFFF_FFFC;
      end
      if (rv)
         memPending = 1'b0;
      else if (memPending)
         memDelay--;
      if (granted) begin
         memPending = 1'b1;
         memDelay = $urandom_range(0, latMax);
      end
      @(negedge clk);
   endtask

   initial begin
      bit          rndRedir;
      bit          rndRv;
      logic [31:0] rndPc;

      rst_n = 1'b0;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      id_ready = 1'b0;
      latMax = 0;
      fixData = 1'b1;
      fixedData = 32'h0050_0093;
      modelReset();
      @(negedge clk);
      @(negedge clk);
      checkReset("reset");

      // First fetch after reset with a single-cycle memory.
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("first_valid", 32'(instr_valid), 32'h1);
      checkOutput("first_instr", instr, 32'h0050_0093);
      checkOutput("first_pc", instr_pc, 32'h0);
      fixData = 1'b0;

      // Decoder stalled: buffer fills to two entries and fetching stops.
      for (int i = 0; i < 10; i++)
         applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("stall_pc", instr_pc, 32'h0);
      checkOutput("stall_req", 32'(imem_req), 32'h0);
      checkOutput("stall_fpc", imem_addr, 32'h8);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("drain_pc", instr_pc, 32'h4);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("drain_empty", 32'(instr_valid), 32'h0);

      // Redirect while a request is in flight: its response is dropped.
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      memDelay = 2;
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0102, 1'b0);
      checkOutput("drop_req", 32'(imem_req), 32'h0);
      checkOutput("drop_addr", imem_addr, 32'h0000_0100);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("drop_discard", 32'(instr_valid), 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("redir_valid", 32'(instr_valid), 32'h1);
      checkOutput("redir_pc", instr_pc, 32'h0000_0100);

      // Redirect coincident with the returning word.
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
      checkOutput("coinc_valid", 32'(instr_valid), 32'h0);
      checkOutput("coinc_instr", instr, TB_NOP);
      checkOutput("coinc_addr", imem_addr, 32'h0000_0200);

      // Fetch address wraps from the top of the address space.
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
      checkOutput("wrap_top", imem_addr, 32'hFFFF_FFFC);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("wrap_zero", imem_addr, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("wrap_pc", instr_pc, 32'hFFFF_FFFC);

      // Reset in the middle of a request; a late rvalid must be ignored.
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      memDelay = 3;
      rst_n = 1'b0;
      #1;
      checkReset("midreset");
      @(negedge clk);
      @(negedge clk);
      modelReset();
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("late_rv_valid", 32'(instr_valid), 32'h0);
      checkOutput("late_rv_addr", imem_addr, TB_RESET_PC);

      // Random traffic: grant, stall, redirect and spurious rvalid.
      latMax = 2;
      for (int i = 0; i < 2000; i++) begin
         rndRedir = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 3) == 0)
            rndPc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
         else
            rndPc = $urandom;
         rndRv = !memPending && ($urandom_range(0, 7) == 0);
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                       rndRedir, rndPc, rndRv);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
